lsu_bus_bridge: RTL and testbench
=================================

LSU_BUS_BRIDGE -- requirements
Module: lsu_bus_bridge

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, giving the maximum bus wait cycles before timeout.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port mem_read, input, 1: load request from the datapath.
REQ-005 SHALL have port mem_write, input, 1: store request from the datapath.
REQ-006 SHALL have port funct3, input, 3: access size/sign selector.
REQ-007 SHALL have port addr, input, 32: byte address (ALU result).
REQ-008 SHALL have port wr_data, input, 32: store data (rs2).
REQ-009 SHALL have port rd_data, output, 32: extended load result.
REQ-010 SHALL have port stall, output, 1: freeze PC and register writes.
REQ-011 SHALL have port fault, output, 1: one-cycle pulse on error.
REQ-012 SHALL have bus ports: bus_req out 1, bus_we out 1, bus_addr out 32, bus_wdata out 32, bus_be out 4, bus_ready in 1, bus_rdata in 32.

Function
REQ-013 SHALL implement states IDLE, REQ, DONE and ERR.
REQ-014 stall SHALL equal (mem_read|mem_write) in IDLE and REQ, and 0 in DONE and ERR.
REQ-015 In IDLE with a request, SHALL register bus_addr={addr[31:2],2'b00}, bus_we, bus_be and bus_wdata, then go to REQ.
REQ-016 bus_req SHALL be 1 only in REQ; bus fields SHALL stay stable while bus_req=1.
REQ-017 In REQ, bus_ready=1 SHALL capture bus_rdata and move to DONE; total latency is 2 cycles minimum from IDLE to DONE.
REQ-018 In DONE, rd_data SHALL present the extended captured data; next state SHALL be IDLE.
REQ-019 A wait counter SHALL clear on REQ entry; after WAIT_MAX REQ cycles without bus_ready, the state SHALL become ERR.
REQ-020 ERR SHALL drive fault=1 and rd_data=0 for one cycle, then return to IDLE.
REQ-021 If mem_read and mem_write are both 1, the write SHALL take priority.
REQ-022 Byte enables SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
REQ-023 Store data SHALL be replicated: byte x4, halfword x2, word as-is.
REQ-024 Loads SHALL select lanes by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-025 funct3 011, 110 or 111 (and 100, 101 for stores) SHALL go IDLE->ERR with no bus access.
REQ-026 With no request in IDLE, SHALL hold: stall=0, bus_req=0.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, bus_req=0, fault=0, stall=0, rd_data=0, bus_be=0, bus_addr=0, bus_wdata=0, bus_we=0, wait counter=0.
REQ-028 A reset during REQ SHALL abandon the access; no data SHALL be captured.

Configuration
REQ-029 With MISALIGN_TRAP_EN defined, a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL go IDLE->ERR with no bus access.
REQ-030 Without MISALIGN_TRAP_EN, misaligned accesses SHALL proceed with offending low address bits treated as 0 (halfword: bit0; word: bits1:0).

Structure
REQ-031 Package lsu_pkg SHALL hold the state enum, funct3 constants (LB..LHU, SB..SW) and the WAIT_MAX default.
REQ-032 Load lane select and extension SHALL be a combinational sub-module lsu_load_ext.

Verification
REQ-033 SW addr=0x100, wr_data=0xDEADBEEF, bus_ready after 3 cycles -> bus_be=1111, bus_addr=0x100, stall high 4 cycles, then DONE.
REQ-034 LB addr=0x203, bus_rdata=0x80000000 -> rd_data=0xFFFFFF80; LBU gives 0x00000080.
REQ-035 SH addr=0x102, wr_data=0x0000ABCD -> bus_be=1100, bus_wdata=0xABCDABCD.
REQ-036 Read, bus_ready held 0 -> after WAIT_MAX cycles, fault=1 for one cycle, rd_data=0, stall drops.
REQ-037 LW addr=0x101: with MISALIGN_TRAP_EN -> fault and no bus_req; without it -> bus_addr=0x100 and a normal load.
REQ-038 reset asserted mid-REQ -> bus_req=0 immediately, state IDLE; next request completes normally.

Source files
------------

// File: rtl/lsu_bus_bridge_pkg.sv
// Shared types and constants for the LSU-to-bus bridge: FSM states, funct3 encodings,
// the default bus timeout and a funct3 legality helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone,
        StErr
    } state_e;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;

    localparam int unsigned WaitMaxDefault = 15;

    function automatic logic f3_valid(logic [2:0] f3, logic we);
        if (we) begin
            return f3 inside {F3Sb, F3Sh, F3Sw};
        end
        return f3 inside {F3Lb, F3Lh, F3Lw, F3Lbu, F3Lhu};
    endfunction

endpackage

// File: rtl/lsu_bus_bridge_if.sv
// Simple request/ready memory bus between the LSU bridge (master) and a memory (slave).
interface lsu_bus_bridge_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ready, bus_rdata
    );

endinterface

// File: rtl/lsu_load_ext.sv
// Load result formatter: picks the byte/halfword lane by address offset and extends it.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        unique case (off_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = '0;
        case (funct3_i)
            F3Lb:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3Lh:    data_o = {{16{half_sel[15]}}, half_sel};
            F3Lw:    data_o = rdata_i;
            F3Lbu:   data_o = {24'h000000, byte_sel};
            F3Lhu:   data_o = {16'h0000, half_sel};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Bridges datapath load/store requests onto a request/ready bus with timeout and faults.
// Optional MISALIGN_TRAP_EN: misaligned halfword/word accesses fault instead of truncating.
module lsu_bus_bridge
    import lsu_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WaitMaxDefault
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          funct3,
    input  logic [31:0]         addr,
    input  logic [31:0]         wr_data,
    output logic [31:0]         rd_data,
    output logic                stall,
    output logic                fault,
    lsu_bus_bridge_if.master    bus
);

    localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_q, wait_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic [31:0]     rdata_q, rdata_d;

    logic        req, misalign, access_ok;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [1:0]  off_calc;
    logic [31:0] ext_data;

    assign req = mem_read | mem_write;

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // mem_write wins when both requests are raised.
    assign access_ok = f3_valid(funct3, mem_write) && !misalign;

    // Offending low bits are dropped for halfwords/words so lanes stay naturally aligned.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = wr_data;
        off_calc   = 2'b00;
        case (funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wr_data[7:0]}};
                off_calc   = addr[1:0];
            end
            2'b01: begin
                be_calc    = 4'b0011 << {addr[1], 1'b0};
                wdata_calc = {2{wr_data[15:0]}};
                off_calc   = {addr[1], 1'b0};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = wr_data;
                off_calc   = 2'b00;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (!access_ok) begin
                        state_d = StErr;
                    end else begin
                        state_d = StReq;
                        wait_d  = '0;
                        we_d    = mem_write;
                        addr_d  = {addr[31:2], 2'b00};
                        wdata_d = wdata_calc;
                        be_d    = be_calc;
                        f3_d    = funct3;
                        off_d   = off_calc;
                    end
                end
            end
            StReq: begin
                if (bus.bus_ready) begin
                    state_d = StDone;
                    rdata_d = bus.bus_rdata;
                end else if (wait_q == CntW'(WAIT_MAX - 1)) begin
                    state_d = StErr;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            wait_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
        end
    end

    lsu_load_ext u_load_ext (
        .funct3_i (f3_q),
        .off_i    (off_q),
        .rdata_i  (rdata_q),
        .data_o   (ext_data)
    );

    assign bus.bus_req   = (state_q == StReq);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_be    = be_q;

    // Reset gates stall so a held request cannot freeze the core while in reset.
    assign stall   = reset & req & ((state_q == StIdle) || (state_q == StReq));
    assign fault   = (state_q == StErr);
    assign rd_data = ((state_q == StDone) && !we_q) ? ext_data : '0;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed testbench for lsu_bus_bridge: loads, stores, timeout, illegal funct3,
// misalignment handling and reset during an outstanding request.
module tb_lsu_bus_bridge;
    import lsu_pkg::*;

    localparam int unsigned WaitMax = 15;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        stall;
    logic        fault;

    int checks = 0;
    int errors = 0;

    lsu_bus_bridge_if bif ();

    lsu_bus_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .stall     (stall),
        .fault     (fault),
        .bus       (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdat, input logic [31:0] exp_addr,
                           input logic [31:0] exp_rd);
        @(negedge clk);
        mem_read = 1'b1;
        funct3   = f3;
        addr     = a;
        #1 chk({tag, "_idle_stall"}, stall, 1);
        @(negedge clk);
        bif.bus_ready = 1'b1;
        bif.bus_rdata = rdat;
        #1 chk({tag, "_req"}, bif.bus_req, 1);
        chk({tag, "_addr"}, bif.bus_addr, exp_addr);
        chk({tag, "_we"}, bif.bus_we, 0);
        @(negedge clk);
        bif.bus_ready = 1'b0;
        bif.bus_rdata = 32'h0;
        mem_read      = 1'b0;
        #1 chk({tag, "_rd"}, rd_data, exp_rd);
        chk({tag, "_done_stall"}, stall, 0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        @(negedge clk);
        mem_write = 1'b1;
        funct3    = f3;
        addr      = a;
        wr_data   = wd;
        #1;
        @(negedge clk);
        bif.bus_ready = 1'b1;
        #1 chk({tag, "_req"}, bif.bus_req, 1);
        chk({tag, "_addr"}, bif.bus_addr, exp_addr);
        chk({tag, "_be"}, {28'h0, bif.bus_be}, {28'h0, exp_be});
        chk({tag, "_wdata"}, bif.bus_wdata, exp_wd);
        chk({tag, "_we"}, bif.bus_we, 1);
        @(negedge clk);
        bif.bus_ready = 1'b0;
        mem_write     = 1'b0;
        #1 chk({tag, "_done_stall"}, stall, 0);
        chk({tag, "_done_rd"}, rd_data, 0);
    endtask

    // Request that must fault straight from IDLE without touching the bus.
    task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a);
        @(negedge clk);
        mem_read  = ~we;
        mem_write = we;
        funct3    = f3;
        addr      = a;
        #1 chk({tag, "_idle_stall"}, stall, 1);
        @(negedge clk);
        #1 chk({tag, "_fault"}, fault, 1);
        chk({tag, "_noreq"}, bif.bus_req, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_rd"}, rd_data, 0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        #1 chk({tag, "_fault_clr"}, fault, 0);
    endtask

    initial begin
        int n_stall;
        int n_req;

        reset         = 1'b0;
        mem_read      = 1'b1;
        mem_write     = 1'b0;
        funct3        = F3Lw;
        addr          = 32'h0000_0010;
        wr_data       = 32'h0;
        bif.bus_ready = 1'b0;
        bif.bus_rdata = 32'h0;

        #2;
        chk("rst_bus_req", bif.bus_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_fault", fault, 0);
        chk("rst_rd", rd_data, 0);
        chk("rst_be", {28'h0, bif.bus_be}, 0);
        chk("rst_addr", bif.bus_addr, 0);
        chk("rst_wdata", bif.bus_wdata, 0);
        chk("rst_we", bif.bus_we, 0);
        mem_read = 1'b0;

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1 chk("idle_stall", stall, 0);
        chk("idle_req", bif.bus_req, 0);

        // SW with bus_ready on the third REQ cycle.
        n_stall = 0;
        @(negedge clk);
        mem_write = 1'b1;
        funct3    = F3Sw;
        addr      = 32'h0000_0100;
        wr_data   = 32'hDEAD_BEEF;
        #1 n_stall += int'(stall);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) bif.bus_ready = 1'b1;
            #1 n_stall += int'(stall);
            chk($sformatf("sw_req%0d", i), bif.bus_req, 1);
        end
        chk("sw_be", {28'h0, bif.bus_be}, 32'hF);
        chk("sw_addr", bif.bus_addr, 32'h0000_0100);
        chk("sw_wdata", bif.bus_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        bif.bus_ready = 1'b0;
        mem_write     = 1'b0;
        #1 n_stall += int'(stall);
        chk("sw_stall_cycles", n_stall, 4);
        chk("sw_done_req", bif.bus_req, 0);
        chk("sw_done_fault", fault, 0);

        do_load("lb", F3Lb, 32'h0000_0203, 32'h8000_0000, 32'h0000_0200, 32'hFFFF_FF80);
        do_load("lbu", F3Lbu, 32'h0000_0203, 32'h8000_0000, 32'h0000_0200, 32'h0000_0080);
        do_load("lb0", F3Lb, 32'h0000_0200, 32'h0000_007F, 32'h0000_0200, 32'h0000_007F);
        do_load("lh", F3Lh, 32'h0000_0202, 32'h8001_0000, 32'h0000_0200, 32'hFFFF_8001);
        do_load("lhu", F3Lhu, 32'h0000_0202, 32'h8001_0000, 32'h0000_0200, 32'h0000_8001);
        do_load("lw", F3Lw, 32'h0000_0204, 32'h1234_5678, 32'h0000_0204, 32'h1234_5678);

        do_store("sh", F3Sh, 32'h0000_0102, 32'h0000_ABCD, 32'h0000_0100, 4'b1100,
                 32'hABCD_ABCD);
        do_store("sb", F3Sb, 32'h0000_0101, 32'h0000_0012, 32'h0000_0100, 4'b0010,
                 32'h1212_1212);

        // Both requests raised: the store must win.
        @(negedge clk);
        mem_read  = 1'b1;
        mem_write = 1'b1;
        funct3    = F3Sw;
        addr      = 32'h0000_0500;
        wr_data   = 32'h5555_AAAA;
        @(negedge clk);
        bif.bus_ready = 1'b1;
        #1 chk("prio_we", bif.bus_we, 1);
        chk("prio_wdata", bif.bus_wdata, 32'h5555_AAAA);
        @(negedge clk);
        bif.bus_ready = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        #1 chk("prio_rd", rd_data, 0);

        // Timeout: bus_ready never arrives.
        @(negedge clk);
        mem_read = 1'b1;
        funct3   = F3Lw;
        addr     = 32'h0000_0300;
        n_req    = 0;
        for (int i = 0; i < int'(WaitMax); i++) begin
            @(negedge clk);
            #1 n_req += int'(bif.bus_req & stall);
        end
        chk("tmo_req_cycles", n_req, WaitMax);
        @(negedge clk);
        #1 chk("tmo_fault", fault, 1);
        chk("tmo_rd", rd_data, 0);
        chk("tmo_stall", stall, 0);
        chk("tmo_req", bif.bus_req, 0);
        mem_read = 1'b0;
        @(negedge clk);
        #1 chk("tmo_fault_clr", fault, 0);

        do_err("ld_f3_011", 1'b0, 3'b011, 32'h0000_0400);
        do_err("ld_f3_111", 1'b0, 3'b111, 32'h0000_0400);
        do_err("st_f3_100", 1'b1, 3'b100, 32'h0000_0400);

`ifdef MISALIGN_TRAP_EN
        do_err("lw_mis", 1'b0, F3Lw, 32'h0000_0101);
        do_err("lh_mis", 1'b0, F3Lh, 32'h0000_0103);
`else
        do_load("lw_mis", F3Lw, 32'h0000_0101, 32'hCAFE_F00D, 32'h0000_0100, 32'hCAFE_F00D);
        do_load("lh_mis", F3Lh, 32'h0000_0103, 32'h7FFF_0000, 32'h0000_0100, 32'h0000_7FFF);
`endif

        // Reset while a read is outstanding.
        @(negedge clk);
        mem_read = 1'b1;
        funct3   = F3Lw;
        addr     = 32'h0000_0600;
        @(negedge clk);
        #1 chk("rstreq_pre_req", bif.bus_req, 1);
        bif.bus_rdata = 32'hBAD0_BAD0;
        #1 reset = 1'b0;
        #1 chk("rstreq_req", bif.bus_req, 0);
        chk("rstreq_stall", stall, 0);
        chk("rstreq_addr", bif.bus_addr, 0);
        chk("rstreq_rd", rd_data, 0);
        mem_read      = 1'b0;
        bif.bus_rdata = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        do_load("post_rst", F3Lw, 32'h0000_0604, 32'h1111_2222, 32'h0000_0604, 32'h1111_2222);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
